// File: rtl/cacheline_adaptor_pkg.sv
// rtl/cacheline_adaptor_pkg.sv - shared widths, state encoding and address helper for cacheline_adaptor
// Optional feature macro: CACHELINE_ADAPTOR_EARLY_RESP_EN (drops the DONE state).
package cacheline_adaptor_pkg;

  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int ADDR_W = 32;
  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int CNT_W  = $clog2(BEATS);

  localparam logic [ADDR_W-1:0] LINE_OFFSET_MASK = 'h1F;
  localparam logic [CNT_W-1:0]  LAST_BEAT        = CNT_W'(BEATS - 1);

`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } adaptor_state_e;
`else
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } adaptor_state_e;
`endif

  function automatic logic [ADDR_W-1:0] align_line(input logic [ADDR_W-1:0] addr);
    return addr & ~LINE_OFFSET_MASK;
  endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// rtl/cacheline_adaptor_if.sv - cache-side and burst-memory-side signal bundle for cacheline_adaptor
// slave: the adaptor's view; master: the arbiter/memory environment's view.
interface cacheline_adaptor_if;
  import cacheline_adaptor_pkg::*;

  logic [ADDR_W-1:0] cache_addr;
  logic [LINE_W-1:0] cache_wdata;
  logic              cache_read;
  logic              cache_write;
  logic              cache_resp;
  logic [LINE_W-1:0] cache_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [BEAT_W-1:0] mem_wdata;
  logic [BEAT_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  cache_addr,
    input  cache_wdata,
    input  cache_read,
    input  cache_write,
    output cache_resp,
    output cache_rdata,
    output mem_addr,
    output mem_read,
    output mem_write,
    output mem_wdata,
    input  mem_rdata,
    input  mem_resp
  );

  modport master (
    output cache_addr,
    output cache_wdata,
    output cache_read,
    output cache_write,
    input  cache_resp,
    input  cache_rdata,
    input  mem_addr,
    input  mem_read,
    input  mem_write,
    input  mem_wdata,
    output mem_rdata,
    output mem_resp
  );

endinterface

// File: rtl/cacheline_buffer.sv
// rtl/cacheline_buffer.sv - line register with full-line load, per-beat write and beat read mux
// Shared by read and write bursts since only one is ever in flight.
module cacheline_buffer
  import cacheline_adaptor_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              beat_we,
  input  logic [CNT_W-1:0]  beat_idx,
  input  logic [BEAT_W-1:0] beat_wdata,
  output logic [BEAT_W-1:0] beat_rdata,
  output logic [LINE_W-1:0] line
);

  logic [LINE_W-1:0] line_d;
  logic [LINE_W-1:0] line_q;

  always_comb begin
    line_d = line_q;
    if (load) begin
      line_d = load_line;
    end else if (beat_we) begin
      line_d[BEAT_W*beat_idx +: BEAT_W] = beat_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign beat_rdata = line_q[BEAT_W*beat_idx +: BEAT_W];
  assign line       = line_q;

endmodule

// File: rtl/cacheline_adaptor.sv
// rtl/cacheline_adaptor.sv - 256-bit cacheline to four-beat 64-bit burst adaptor
// Optional feature macro: CACHELINE_ADAPTOR_EARLY_RESP_EN (combinational response on the last beat).
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  cacheline_adaptor_if.slave  bus
);

  adaptor_state_e    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;

  logic              in_burst;
  logic              last_beat;
  logic              buf_load;
  logic              beat_we;
  logic [BEAT_W-1:0] buf_beat;
  logic [LINE_W-1:0] buf_line;

  assign in_burst  = (state_q == RD_BURST) || (state_q == WR_BURST);
  assign last_beat = in_burst && bus.mem_resp && (cnt_q == LAST_BEAT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    buf_load = 1'b0;
    beat_we  = 1'b0;

    case (state_q)
      IDLE: begin
        // A simultaneous read stays pending behind the write.
        if (bus.cache_write) begin
          state_d  = WR_BURST;
          addr_d   = align_line(bus.cache_addr);
          buf_load = 1'b1;
        end else if (bus.cache_read) begin
          state_d = RD_BURST;
          addr_d  = align_line(bus.cache_addr);
        end
      end
      RD_BURST, WR_BURST: begin
        if (bus.mem_resp) begin
          beat_we = (state_q == RD_BURST);
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_beat) begin
            cnt_d = '0;
`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
            state_d = IDLE;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifndef CACHELINE_ADAPTOR_EARLY_RESP_EN
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
`endif
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    mem_read_d  = (state_d == RD_BURST);
    mem_write_d = (state_d == WR_BURST);
  end

`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end
`else
  logic cache_resp_q, cache_resp_d;

  assign cache_resp_d = (state_d == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      cache_resp_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      cache_resp_q <= cache_resp_d;
    end
  end
`endif

  cacheline_buffer u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .load_line  (bus.cache_wdata),
    .beat_we    (beat_we),
    .beat_idx   (cnt_q),
    .beat_wdata (bus.mem_rdata),
    .beat_rdata (buf_beat),
    .line       (buf_line)
  );

  assign bus.mem_addr  = addr_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_wdata = buf_beat;

`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
  // The final read beat has not reached the buffer yet, so forward it straight through.
  assign bus.cache_resp  = last_beat;
  assign bus.cache_rdata = (state_q == RD_BURST && last_beat)
                         ? {bus.mem_rdata, buf_line[LINE_W-BEAT_W-1:0]}
                         : buf_line;
`else
  assign bus.cache_resp  = cache_resp_q;
  assign bus.cache_rdata = buf_line;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb/tb_cacheline_adaptor.sv - directed, table-driven self-checking bench for cacheline_adaptor
module tb_cacheline_adaptor;

`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
  localparam int EARLY = 1;
`else
  localparam int EARLY = 0;
`endif

  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct {
    bit           is_write;
    logic [31:0]  addr;
    logic [255:0] line;
    logic [15:0]  pat;
    logic [31:0]  exp_addr;
    int           exp_resp_cyc;
    logic [255:0] exp_rdata;
  } vec_t;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;
  vec_t vecs[5];

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int beats;
    int resp_cyc;
    beats    = 0;
    resp_cyc = -1;
    @(negedge clk);
    bus.cache_addr  = v.addr;
    bus.cache_wdata = v.is_write ? v.line : '1;
    bus.cache_read  = !v.is_write;
    bus.cache_write = v.is_write;
    bus.mem_resp    = 1'b0;
    for (int cyc = 1; cyc <= 40 && resp_cyc < 0; cyc++) begin
      @(posedge clk);
      #1;
      bus.mem_resp  = (beats < 4) && ((cyc > 16) || v.pat[cyc-1]);
      bus.mem_rdata = (bus.mem_resp && !v.is_write) ? v.line[64*beats +: 64] : JUNK;
      #1;
      if (cyc == 1) begin
        check("burst_rw", 256'({bus.mem_read, bus.mem_write}), 256'(v.is_write ? 2'b01 : 2'b10));
        check("mem_addr", 256'(bus.mem_addr), 256'(v.exp_addr));
      end
      if (bus.mem_resp && v.is_write) begin
        check("mem_wdata", 256'(bus.mem_wdata), 256'(v.line[64*beats +: 64]));
      end
      if (bus.mem_resp) beats++;
      if (bus.cache_resp) begin
        resp_cyc = cyc;
        check("resp_cycle", 256'(cyc), 256'(v.exp_resp_cyc - EARLY));
        check("rdata_at_resp", bus.cache_rdata, v.exp_rdata);
        bus.cache_read  = 1'b0;
        bus.cache_write = 1'b0;
      end
    end
    if (resp_cyc < 0) begin
      check("resp_timeout", 256'(1'b0), 256'(1'b1));
      bus.cache_read  = 1'b0;
      bus.cache_write = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = JUNK;
    #1;
    check("post_resp_quiet", 256'({bus.mem_read, bus.mem_write, bus.cache_resp}), 256'(3'b000));
    check("rdata_hold", bus.cache_rdata, v.exp_rdata);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;

    vecs[0] = '{is_write: 1'b0, addr: 32'h0000_1234,
                line: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                pat: 16'hFFFF, exp_addr: 32'h0000_1220, exp_resp_cyc: 5,
                exp_rdata: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    vecs[1] = '{is_write: 1'b1, addr: 32'h0000_0100,
                line: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                pat: 16'hFFFF, exp_addr: 32'h0000_0100, exp_resp_cyc: 5,
                exp_rdata: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                            64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}};
    vecs[2] = '{is_write: 1'b0, addr: 32'h0000_0200,
                line: {64'h3132_3334_3536_3738, 64'h2122_2324_2526_2728,
                       64'h1112_1314_1516_1718, 64'h0102_0304_0506_0708},
                pat: 16'hFFFF, exp_addr: 32'h0000_0200, exp_resp_cyc: 5,
                exp_rdata: {64'h3132_3334_3536_3738, 64'h2122_2324_2526_2728,
                            64'h1112_1314_1516_1718, 64'h0102_0304_0506_0708}};
    // mem_resp 1,0,0,1,1,0,1: beats on cycles 1,4,5,7
    vecs[3] = '{is_write: 1'b0, addr: 32'h0000_003F,
                line: {64'hC3C3_C3C3_0000_0003, 64'hC2C2_C2C2_0000_0002,
                       64'hC1C1_C1C1_0000_0001, 64'hC0C0_C0C0_0000_0000},
                pat: 16'h0059, exp_addr: 32'h0000_0020, exp_resp_cyc: 8,
                exp_rdata: {64'hC3C3_C3C3_0000_0003, 64'hC2C2_C2C2_0000_0002,
                            64'hC1C1_C1C1_0000_0001, 64'hC0C0_C0C0_0000_0000}};
    vecs[4] = '{is_write: 1'b1, addr: 32'hFFFF_FFFF,
                line: {64'h0F0F_0F0F_0F0F_0F03, 64'h0F0F_0F0F_0F0F_0F02,
                       64'h0F0F_0F0F_0F0F_0F01, 64'h0F0F_0F0F_0F0F_0F00},
                pat: 16'h0059, exp_addr: 32'hFFFF_FFE0, exp_resp_cyc: 8,
                exp_rdata: {64'h0F0F_0F0F_0F0F_0F03, 64'h0F0F_0F0F_0F0F_0F02,
                            64'h0F0F_0F0F_0F0F_0F01, 64'h0F0F_0F0F_0F0F_0F00}};

    rst_n           = 1'b0;
    bus.cache_addr  = 32'hFFFF_FFFF;
    bus.cache_wdata = '1;
    bus.cache_read  = 1'b0;
    bus.cache_write = 1'b0;
    bus.mem_rdata   = JUNK;
    bus.mem_resp    = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_resp", 256'(bus.cache_resp), 256'(1'b0));
    check("rst_rw", 256'({bus.mem_read, bus.mem_write}), 256'(2'b00));
    check("rst_rdata", bus.cache_rdata, 256'(0));
    check("rst_mem_addr", 256'(bus.mem_addr), 256'(0));
    check("rst_mem_wdata", 256'(bus.mem_wdata), 256'(0));
    rst_n = 1'b1;

    // Stray mem_resp while idle must not advance the beat counter or touch the buffer.
    @(negedge clk);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
    repeat (3) begin
      @(negedge clk);
      check("idle_stray_rw", 256'({bus.mem_read, bus.mem_write, bus.cache_resp}), 256'(3'b000));
    end
    check("idle_stray_rdata", bus.cache_rdata, 256'(0));
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = JUNK;

    // Consecutive entries run back-to-back: each request lands in the idle cycle after the last response.
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i]);
    end

    // Reset after the second beat of a read.
    @(negedge clk);
    bus.cache_addr = 32'h0000_0040;
    bus.cache_read = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk);
      #1;
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = 64'h7777_0000_0000_0000 | 64'(b);
    end
    @(posedge clk);
    #1;
    bus.mem_resp = 1'b0;
    rst_n        = 1'b0;
    #1;
    check("abort_mem_read", 256'(bus.mem_read), 256'(1'b0));
    check("abort_resp", 256'(bus.cache_resp), 256'(1'b0));
    check("abort_rdata", bus.cache_rdata, 256'(0));
    check("abort_mem_addr", 256'(bus.mem_addr), 256'(0));
    bus.cache_read = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_resp", 256'({bus.cache_resp, bus.mem_read}), 256'(2'b00));
    end

    run_txn(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
